fu_nrm_lz_pipe: RTL and testbench
=================================

FU_NRM_LZ_PIPE -- requirements
Module: fu_nrm_lz_pipe

Interface
REQ-001 Parameter: RES_W, default 163, width of the adder result being normalized.
REQ-002 Parameter: NGRP, default 11, number of 16-bit group-OR flags supplied.
REQ-003 nclk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ex5_act  input  1  valid for this cycle's ex5 result.
REQ-006 f_add_ex5_res  input  [0:162]  adder result; bit 0 is MSB.
REQ-007 ex5_or_grp16  input  [0:10]  group-OR flags. Group 0 = bits 0-7. Group g (1-9) = bits 8+16(g-1) through 23+16(g-1). Group 10 = bits 152-162.
REQ-008 ex6_hold  input  1  pipeline stall.
REQ-009 flush  input  1  kill all in-flight operations.
REQ-010 ex7_nrm_vld  output  1  ex7 result valid.
REQ-011 ex7_lz_amt  output  [0:7]  leading-zero count, unsigned, range 0-163.
REQ-012 ex7_nrm_zero  output  1  result was all-zero.

Function
REQ-013 ex5 stage: combinational priority encode of ex5_or_grp16.
- Lowest index set = leading group G.
- Extract a 16-bit slice starting at group G's first bit.
- Group 0 slice: bits 0-7 followed by 8 zeros.
- Group 10 slice: bits 152-162 followed by 5 zeros.
REQ-014 ex6 register (capture condition ex5_act & ~ex6_hold & ~flush) holds:
- group start offset, 8 bits (0, 8, 24, ..., 152)
- 16-bit slice
- any-group flag
- ex6 valid bit
REQ-015 ex6 stage: leading-zero count of the slice (0-15).
- ex6 amount = start offset + slice count, 8-bit unsigned add, no overflow possible.
REQ-016 ex7 register captures ex6 amount, zero flag and valid when ~ex6_hold.
REQ-017 Latency: exactly 2 cycles from ex5_act to ex7_nrm_vld when there is no stall.
- Throughput: one operation per cycle.
REQ-018 All-zero result (no group flag set):
- ex7_lz_amt = 163
- ex7_nrm_zero = 1
- slice is ignored.
REQ-019 A nonzero result yields ex7_nrm_zero = 0.
- ex7_lz_amt equals the index of the first 1 bit of f_add_ex5_res.
REQ-020 Group flags are trusted.
- A flag/data mismatch (flag set, slice zero) yields offset+16, clamped to 163.
- No further checking.
REQ-021 ex6_hold = 1:
- ex6 and ex7 registers, including valids, retain their values.
- ex5 input is not captured; upstream holds it.
REQ-022 flush = 1:
- ex6 and ex7 valid bits clear on the next edge.
- Data registers may update freely.
- flush has priority over ex6_hold and ex5_act.
REQ-023 flush and ex5_act asserted in the same cycle: the ex5 operation is discarded.
REQ-024 Outputs are driven only from ex7 registers; there is no combinational path from inputs to outputs.

Reset
REQ-025 rst asserted: immediately force the following to 0, regardless of nclk.
- ex6 and ex7 valid bits
- ex7_lz_amt
- ex7_nrm_zero
REQ-026 rst deasserted: the first capture occurs on the first rising nclk edge at which ex5_act = 1.
REQ-027 rst asserted mid-operation discards all in-flight operations; no partial result is emitted.

Structure
REQ-028 The shared FU package holds:
- RES_W = 163, NGRP = 11, GRP_W = 16, LZ_W = 8
- LZ_ALLZERO = 163
- the group start-offset table constant
REQ-029 One sub-module, fu_nrm_lzc16, provides the combinational 16-bit leading-zero count.
- Outputs: 4-bit count and an all-zero flag.
- Instantiated once in the ex6 stage.
REQ-030 Total RTL size is 120-400 lines; there are no memories.

Verification
REQ-031 Only bit 0 set, ex5_act = 1 at cycle T:
- cycle T+2: ex7_nrm_vld = 1, ex7_lz_amt = 0, ex7_nrm_zero = 0.
REQ-032 Only bit 162 set (flag 10): ex7_lz_amt = 162.
- Only bit 8 set: ex7_lz_amt = 8.
- Only bit 151 set: ex7_lz_amt = 151.
REQ-033 All-zero result with all flags 0: ex7_lz_amt = 163, ex7_nrm_zero = 1.
REQ-034 Back-to-back ops A, B, C, with ex6_hold = 1 for 3 cycles after B enters ex6:
- Outputs appear in order A, B, C.
- B's result stalls; C is neither duplicated nor lost.
REQ-035 flush asserted in the cycle after A is accepted, with B presented simultaneously:
- Neither A nor B ever produces ex7_nrm_vld = 1.
REQ-036 rst pulsed asynchronously while two operations are in flight:
- ex7_nrm_vld = 0 immediately.
- No stale result appears after release.

Source files
------------

// File: rtl/fu_nrm_lz_pipe_pkg.sv
// Shared constants, types and helpers for the normalizer leading-zero pipeline.
package fu_nrm_lz_pipe_pkg;

    localparam int RES_W = 163;
    localparam int NGRP  = 11;
    localparam int GRP_W = 16;
    localparam int LZ_W  = 8;

    localparam logic [LZ_W-1:0] LZ_ALLZERO = 8'd163;

    localparam logic [LZ_W-1:0] GRP_OFF [NGRP] = '{
        8'd0,   8'd8,   8'd24,  8'd40,  8'd56,  8'd72,
        8'd88,  8'd104, 8'd120, 8'd136, 8'd152
    };

    typedef struct packed {
        logic [LZ_W-1:0]  off;
        logic [GRP_W-1:0] slice;
        logic             any;
    } ex6_data_t;

    // Lowest-index set flag; returns 0 when no flag is set.
    function automatic logic [3:0] lead_grp(input logic [0:NGRP-1] flags);
        logic [3:0] grp;
        grp = 4'd0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (flags[g]) begin
                grp = 4'(g);
            end else begin
                grp = grp;
            end
        end
        return grp;
    endfunction

    // A flagged group whose slice is empty reports the end of that group.
    function automatic logic [LZ_W-1:0] grp_end_clamped(input logic [LZ_W-1:0] off);
        logic [LZ_W-1:0] sum;
        sum = off + 8'd16;
        return (sum > LZ_ALLZERO) ? LZ_ALLZERO : sum;
    endfunction

endpackage

// File: rtl/fu_nrm_lz_pipe_lzc16.sv
// Combinational 16-bit leading-zero counter; bit 15 is the most significant.
module fu_nrm_lzc16
    import fu_nrm_lz_pipe_pkg::*;
(
    input  logic [GRP_W-1:0] i_data,
    output logic [3:0]       o_cnt,
    output logic             o_zero
);

    // Highest set bit wins because later loop iterations override earlier ones.
    always_comb begin
        o_cnt  = 4'd0;
        o_zero = (i_data == 16'h0000);
        for (int i = 0; i < GRP_W; i++) begin
            if (i_data[i]) begin
                o_cnt = 4'(GRP_W - 1 - i);
            end else begin
                o_cnt = o_cnt;
            end
        end
    end

endmodule

// File: rtl/fu_nrm_lz_pipe.sv
// Two-stage leading-zero count for the adder result: group select in ex5,
// slice count and offset add in ex6, registered outputs in ex7.
module fu_nrm_lz_pipe #(
    parameter int RES_W = fu_nrm_lz_pipe_pkg::RES_W,
    parameter int NGRP  = fu_nrm_lz_pipe_pkg::NGRP
) (
    input  logic             nclk,
    input  logic             rst,
    input  logic             ex5_act,
    input  logic [0:RES_W-1] f_add_ex5_res,
    input  logic [0:NGRP-1]  ex5_or_grp16,
    input  logic             ex6_hold,
    input  logic             flush,
    output logic             ex7_nrm_vld,
    output logic [0:7]       ex7_lz_amt,
    output logic             ex7_nrm_zero
);

    import fu_nrm_lz_pipe_pkg::*;

    logic [0:RES_W+4]  w_pad;
    logic [3:0]        w_grp;
    logic [LZ_W-1:0]   w_off;
    logic [GRP_W-1:0]  w_slice;
    logic              w_any;

    ex6_data_t         r_ex6;
    logic              r_ex6_vld;
    logic [3:0]        w_lz_cnt;
    logic              w_lz_zero;
    logic [LZ_W-1:0]   w_ex6_amt;
    logic              w_ex6_zero;

    logic              r_ex7_vld;
    logic [LZ_W-1:0]   r_ex7_amt;
    logic              r_ex7_zero;

    // Trailing pad lets the last (11-bit) group use the generic 16-bit slice.
    assign w_pad = {f_add_ex5_res, 5'b00000};

    // ex5: pick the leading flagged group and extract its 16-bit window.
    always_comb begin
        w_grp   = lead_grp(ex5_or_grp16);
        w_any   = |ex5_or_grp16;
        w_off   = 8'd0;
        w_slice = 16'h0000;
        if (w_grp == 4'd0) begin
            w_slice = {f_add_ex5_res[0:7], 8'h00};
        end else begin
            w_off   = GRP_OFF[w_grp];
            w_slice = w_pad[w_off +: GRP_W];
        end
    end

    // ex6 pipeline register; flush beats hold, hold freezes the valid.
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            r_ex6_vld <= 1'b0;
            r_ex6     <= '0;
        end else begin
            if (flush) begin
                r_ex6_vld <= 1'b0;
            end else if (!ex6_hold) begin
                r_ex6_vld <= ex5_act;
            end else begin
                r_ex6_vld <= r_ex6_vld;
            end
            if (ex5_act && !ex6_hold && !flush) begin
                r_ex6 <= '{off: w_off, slice: w_slice, any: w_any};
            end
        end
    end

    fu_nrm_lzc16 u_lzc16 (
        .i_data (r_ex6.slice),
        .o_cnt  (w_lz_cnt),
        .o_zero (w_lz_zero)
    );

    // ex6: combine group offset with the in-slice count.
    always_comb begin
        w_ex6_zero = ~r_ex6.any;
        if (!r_ex6.any) begin
            w_ex6_amt = LZ_ALLZERO;
        end else if (w_lz_zero) begin
            w_ex6_amt = grp_end_clamped(r_ex6.off);
        end else begin
            w_ex6_amt = r_ex6.off + {4'b0000, w_lz_cnt};
        end
    end

    // ex7 output register.
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            r_ex7_vld  <= 1'b0;
            r_ex7_amt  <= 8'd0;
            r_ex7_zero <= 1'b0;
        end else if (flush) begin
            r_ex7_vld  <= 1'b0;
        end else if (!ex6_hold) begin
            r_ex7_vld  <= r_ex6_vld;
            r_ex7_amt  <= w_ex6_amt;
            r_ex7_zero <= w_ex6_zero;
        end else begin
            r_ex7_vld  <= r_ex7_vld;
        end
    end

    assign ex7_nrm_vld  = r_ex7_vld;
    assign ex7_lz_amt   = r_ex7_amt;
    assign ex7_nrm_zero = r_ex7_zero;

endmodule

// File: tb/tb_fu_nrm_lz_pipe.sv
// Scoreboard bench for fu_nrm_lz_pipe: expected results queued at drive time,
// popped whenever the ex7 register takes a new valid result.
module tb_fu_nrm_lz_pipe;

    typedef struct packed {
        logic [7:0] amt;
        logic       zero;
    } exp_t;

    logic         nclk = 1'b0;
    logic         rst;
    logic         ex5_act;
    logic [0:162] f_add_ex5_res;
    logic [0:10]  ex5_or_grp16;
    logic         ex6_hold;
    logic         flush;
    logic         ex7_nrm_vld;
    logic [0:7]   ex7_lz_amt;
    logic         ex7_nrm_zero;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fu_nrm_lz_pipe dut (
        .nclk          (nclk),
        .rst           (rst),
        .ex5_act       (ex5_act),
        .f_add_ex5_res (f_add_ex5_res),
        .ex5_or_grp16  (ex5_or_grp16),
        .ex6_hold      (ex6_hold),
        .flush         (flush),
        .ex7_nrm_vld   (ex7_nrm_vld),
        .ex7_lz_amt    (ex7_lz_amt),
        .ex7_nrm_zero  (ex7_nrm_zero)
    );

    always #5 nclk = ~nclk;

    function automatic int grp_of(input int i);
        if (i < 8) return 0;
        if (i >= 152) return 10;
        return (i - 8) / 16 + 1;
    endfunction

    function automatic logic [0:10] flags_of(input logic [0:162] d);
        logic [0:10] f;
        f = '0;
        for (int i = 0; i < 163; i++) if (d[i]) f[grp_of(i)] = 1'b1;
        return f;
    endfunction

    function automatic exp_t model(input logic [0:162] d);
        exp_t e;
        e.amt  = 8'd163;
        e.zero = 1'b1;
        for (int i = 162; i >= 0; i--) begin
            if (d[i]) begin
                e.amt  = 8'(i);
                e.zero = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard monitor: a new result appears only after an edge with no hold/flush.
    logic mon_hold, mon_flush, mon_rst;
    exp_t mon_e;
    always begin
        @(posedge nclk);
        mon_hold  = ex6_hold;
        mon_flush = flush;
        mon_rst   = rst;
        #1;
        if (!mon_rst && !rst && !mon_hold && !mon_flush && ex7_nrm_vld === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got vld with amt=%0d zero=%0b, required no output",
                         ex7_lz_amt, ex7_nrm_zero);
            end else begin
                mon_e = sbq.pop_front();
                if (ex7_lz_amt !== mon_e.amt || ex7_nrm_zero !== mon_e.zero) begin
                    n_err++;
                    $display("FAIL sb_result: got amt=%0d zero=%0b, required amt=%0d zero=%0b",
                             ex7_lz_amt, ex7_nrm_zero, mon_e.amt, mon_e.zero);
                end
            end
        end
    end

    task automatic send(input logic [0:162] d, input logic [0:10] f,
                        input exp_t e, input bit push);
        @(negedge nclk);
        ex5_act       = 1'b1;
        f_add_ex5_res = d;
        ex5_or_grp16  = f;
        if (push) sbq.push_back(e);
    endtask

    task automatic send_data(input logic [0:162] d);
        send(d, flags_of(d), model(d), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge nclk);
            ex5_act = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(posedge nclk);
            k++;
        end
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex5_act = 1'b0; f_add_ex5_res = '0; ex5_or_grp16 = '0;
        ex6_hold = 1'b0; flush = 1'b0;
        #2;
        n_cmp++;
        if (ex7_nrm_vld !== 1'b0 || ex7_lz_amt !== 8'd0 || ex7_nrm_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got vld=%0b amt=%0d zero=%0b, required 0/0/0",
                     ex7_nrm_vld, ex7_lz_amt, ex7_nrm_zero);
        end
        repeat (2) @(negedge nclk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_latency();
        logic [0:162] d;
        d = '0; d[0] = 1'b1;
        send_data(d);
        @(posedge nclk); #1;
        n_cmp++;
        if (ex7_nrm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got vld=%0b one cycle after accept, required 0", ex7_nrm_vld);
        end
        @(negedge nclk); ex5_act = 1'b0;
        @(posedge nclk); #2;
        n_cmp++;
        if (ex7_nrm_vld !== 1'b1 || ex7_lz_amt !== 8'd0 || ex7_nrm_zero !== 1'b0) begin
            n_err++;
            $display("FAIL latency_bit0: got vld=%0b amt=%0d zero=%0b, required 1/0/0",
                     ex7_nrm_vld, ex7_lz_amt, ex7_nrm_zero);
        end
        wait_drain();
    endtask

    task automatic test_patterns();
        logic [0:162] d;
        int pos [5] = '{162, 8, 151, 7, 40};
        for (int k = 0; k < 5; k++) begin
            d = '0; d[pos[k]] = 1'b1;
            send(d, flags_of(d), '{amt: 8'(pos[k]), zero: 1'b0}, 1'b1);
        end
        d = '0;
        send(d, 11'b0, '{amt: 8'd163, zero: 1'b1}, 1'b1);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = $urandom_range(0, 162);
            d = '0; d[p] = 1'b1;
            for (int i = p + 1; i < 163; i++) d[i] = 1'($urandom_range(0, 1));
            send(d, flags_of(d), '{amt: 8'(p), zero: 1'b0}, 1'b1);
        end
        idle(1);
        wait_drain();
    endtask

    task automatic test_flag_mismatch();
        logic [0:162] d;
        logic [0:10]  f;
        d = '0;
        f = '0; f[3] = 1'b1;
        send(d, f, '{amt: 8'd56, zero: 1'b0}, 1'b1);
        f = '0; f[10] = 1'b1;
        send(d, f, '{amt: 8'd163, zero: 1'b0}, 1'b1);
        f = '0; f[0] = 1'b1;
        send(d, f, '{amt: 8'd16, zero: 1'b0}, 1'b1);
        idle(1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [0:162] da, db, dc;
        exp_t ea;
        da = '0; da[20]  = 1'b1;
        db = '0; db[99]  = 1'b1; db[120] = 1'b1;
        dc = '0; dc[155] = 1'b1;
        ea = model(da);
        send_data(da);
        send_data(db);
        send_data(dc);
        ex6_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge nclk); #1;
            n_cmp++;
            if (ex7_nrm_vld !== 1'b1 || ex7_lz_amt !== ea.amt) begin
                n_err++;
                $display("FAIL hold_retain: got vld=%0b amt=%0d, required 1/%0d",
                         ex7_nrm_vld, ex7_lz_amt, ea.amt);
            end
        end
        @(negedge nclk); ex6_hold = 1'b0;
        idle(1);
        wait_drain();
        idle(3);
    endtask

    task automatic test_flush();
        logic [0:162] d;
        d = '0; d[50] = 1'b1;
        send(d, flags_of(d), model(d), 1'b0);
        d = '0; d[60] = 1'b1;
        send(d, flags_of(d), model(d), 1'b0);
        flush = 1'b1;
        @(negedge nclk);
        flush = 1'b0; ex5_act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge nclk); #1;
            n_cmp++;
            if (ex7_nrm_vld !== 1'b0) begin
                n_err++;
                $display("FAIL flush_kill: got vld=%0b amt=%0d, required vld=0", ex7_nrm_vld, ex7_lz_amt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [0:162] d;
        d = '0; d[30] = 1'b1; send_data(d);
        d = '0; d[90] = 1'b1; send_data(d);
        @(posedge nclk);
        #3;
        rst = 1'b1; ex5_act = 1'b0;
        #1;
        sbq.delete();
        n_cmp++;
        if (ex7_nrm_vld !== 1'b0 || ex7_lz_amt !== 8'd0 || ex7_nrm_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got vld=%0b amt=%0d zero=%0b, required 0/0/0",
                     ex7_nrm_vld, ex7_lz_amt, ex7_nrm_zero);
        end
        repeat (2) @(negedge nclk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge nclk); #1;
            n_cmp++;
            if (ex7_nrm_vld !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stale: got vld=%0b after release, required 0", ex7_nrm_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_flag_mismatch();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_patterns();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
